// File: rtl/uart_rx_deserializer_if.sv
// Parallel-side bundle of the UART receiver: serial line and frame config in,
// received byte and status pulses out.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESC_W-1:0]    prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1/8E1/8O1 frames on an oversampled clock, one-cycle result pulses.
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote per bit.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk_in,
  input  logic                  rst,
  uart_rx_deserializer_if.slave bus
);
  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [1:0]            fill_q, fill_d;
  logic                  armed_q, armed_d;
  logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d, presc_l_q, presc_l_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic                  perr_q, perr_d, par_en_l_q, par_en_l_d, par_typ_l_q, par_typ_l_d;
  logic                  data_valid_q, data_valid_d, par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d, busy_q, busy_d;

  logic [PRESC_W-1:0] half, samp_pt;
  logic               at_samp, wrap, sample;

  assign half = presc_l_q >> 1;
  assign wrap = (edge_cnt_q == presc_l_q - PRESC_W'(1));

`ifdef UART_RX_MAJORITY_EN
  logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  assign samp_pt = half + PRESC_W'(1);
  assign sample  = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
`else
  assign samp_pt = half;
  assign sample  = rx_s_q;
`endif
  assign at_samp = (edge_cnt_q == samp_pt);

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = bus.rx_in;
    rx_s_d       = rx_meta_q;
    // Synchronizer reset value is not a real line sample; arm only once it has flushed.
    fill_d       = {fill_q[0], 1'b1};
    armed_d      = armed_q | (fill_q[1] & rx_s_q);
    edge_cnt_d   = wrap ? '0 : edge_cnt_q + PRESC_W'(1);
    presc_l_d    = presc_l_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    perr_d       = perr_q;
    par_en_l_d   = par_en_l_q;
    par_typ_l_d  = par_typ_l_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    busy_d       = busy_q;
`ifdef UART_RX_MAJORITY_EN
    samp_a_d = (edge_cnt_q == half - PRESC_W'(1)) ? rx_s_q : samp_a_q;
    samp_b_d = (edge_cnt_q == half) ? rx_s_q : samp_b_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        if (armed_q && !rx_s_q) begin
          state_d     = S_START;
          par_en_l_d  = bus.par_en;
          par_typ_l_d = bus.par_typ;
          presc_l_d   = (bus.prescale < PRESC_W'(4)) ? PRESC_W'(4) : bus.prescale;
          bit_cnt_d   = '0;
          perr_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_START: begin
        if (at_samp && sample) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_samp) shift_d = {sample, shift_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) state_d = par_en_l_q ? S_PARITY : S_STOP;
          else bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_PARITY: begin
        if (at_samp && (sample != (par_typ_l_q ? ~^shift_q : ^shift_q))) perr_d = 1'b1;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at the sample point so a start edge right after the stop bit is not missed.
        if (at_samp) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          par_err_d = perr_q;
          stp_err_d = ~sample;
          if (sample && !perr_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      edge_cnt_q   <= '0;
      presc_l_q    <= PRESC_W'(8);
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      perr_q       <= 1'b0;
      par_en_l_q   <= 1'b0;
      par_typ_l_q  <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp_a_q     <= 1'b1;
      samp_b_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      edge_cnt_q   <= edge_cnt_d;
      presc_l_q    <= presc_l_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      perr_q       <= perr_d;
      par_en_l_q   <= par_en_l_d;
      par_typ_l_q  <= par_typ_l_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
`endif
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus random
// frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) bus ();
  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] model_pdata = 8'h00;

  // Output monitor on the inactive edge; each pulse-high cycle counts once.
  always @(negedge clk_in) begin
    if (bus.data_valid) begin
      dv_cnt++;
      rx_q.push_back(bus.p_data);
    end
    if (bus.par_err) pe_cnt++;
    if (bus.stp_err) se_cnt++;
    if (bus.busy)    busy_cyc++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; busy_cyc = 0;
    rx_q.delete();
  endtask

  // Frame-level model: {data_valid, par_err, stp_err}; even parity bit = XOR of data.
  function automatic logic [2:0] model_frame(input logic [7:0] d, input logic pe, input logic pt,
                                             input logic pbit, input logic sbit);
    logic perr;
    perr = pe && (pbit != (pt ? ~(^d) : (^d)));
    return {sbit && !perr, perr, !sbit};
  endfunction

  task automatic drive_bit(input logic v, input int p, input int spike_at);
    for (int c = 0; c < p; c++) begin
      bus.rx_in = (c == spike_at) ? ~v : v;
      tick();
    end
  endtask

  // spike_at offset p/2+1 lands on the single-sample instant (one detect cycle after mid-bit).
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic sbit,
                            input int p, input int spike_bit, input logic scramble);
    logic sv_pe, sv_pt;
    logic [PW-1:0] sv_ps;
    sv_pe = bus.par_en; sv_pt = bus.par_typ; sv_ps = bus.prescale;
    drive_bit(1'b0, p, -1);
    for (int i = 0; i < 8; i++) begin
      if (scramble && i == 1) begin
        bus.par_en   = 1'($urandom);
        bus.par_typ  = 1'($urandom);
        bus.prescale = PW'($urandom);
      end
      if (scramble && i == 6) begin
        bus.par_en = sv_pe; bus.par_typ = sv_pt; bus.prescale = sv_ps;
      end
      drive_bit(d[i], p, (i == spike_bit) ? p / 2 + 1 : -1);
    end
    if (pe) drive_bit(pbit, p, -1);
    drive_bit(sbit, p, -1);
    bus.rx_in = 1'b1;
  endtask

  task automatic set_cfg(input logic pe, input logic pt, input int p);
    bus.par_en = pe; bus.par_typ = pt; bus.prescale = PW'(p);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus.p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", bus.p_data); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", bus.data_valid); end
    checks++; if (bus.par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b want 0", bus.par_err); end
    checks++; if (bus.stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b want 0", bus.stp_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b1;
    repeat (6) tick();
    model_pdata = 8'h00;
  endtask

  task automatic test_basic();
    set_cfg(1'b0, 1'b0, 8);
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, -1, 1'b0);
    repeat (4) tick();
    model_pdata = 8'hA5;
    checks++; if (dv_cnt !== 1) begin errors++; $display("FAIL basic_dv_cnt: got %0d want 1", dv_cnt); end
    checks++; if (bus.p_data !== 8'hA5) begin errors++; $display("FAIL basic_p_data: got %h want a5", bus.p_data); end
    checks++; if (pe_cnt + se_cnt !== 0) begin errors++; $display("FAIL basic_errs: got %0d want 0", pe_cnt + se_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    checks++; if (busy_cyc < 9 * 8 || busy_cyc >= 10 * 8) begin
      errors++; $display("FAIL basic_busy_len: got %0d want 72..79", busy_cyc);
    end
  endtask

  task automatic test_parity();
    set_cfg(1'b1, 1'b0, 16);
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, 1'b0);
    repeat (4) tick();
    model_pdata = 8'h3C;
    checks++; if (dv_cnt !== 1 || pe_cnt !== 0) begin
      errors++; $display("FAIL even_ok: got dv %0d pe %0d want 1 0", dv_cnt, pe_cnt);
    end
    checks++; if (bus.p_data !== 8'h3C) begin errors++; $display("FAIL even_ok_p_data: got %h want 3c", bus.p_data); end
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1, 1'b0);
    repeat (4) tick();
    checks++; if (pe_cnt !== 1 || dv_cnt !== 0 || se_cnt !== 0) begin
      errors++; $display("FAIL even_bad: got pe %0d dv %0d se %0d want 1 0 0", pe_cnt, dv_cnt, se_cnt);
    end
    checks++; if (bus.p_data !== 8'h3C) begin errors++; $display("FAIL even_bad_hold: got %h want 3c", bus.p_data); end
  endtask

  task automatic test_stop_err();
    set_cfg(1'b1, 1'b1, 8);
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 8, -1, 1'b0);
    repeat (3 * 8 + 4) tick();
    checks++; if (se_cnt !== 1 || pe_cnt !== 0 || dv_cnt !== 0) begin
      errors++; $display("FAIL stop_err: got se %0d pe %0d dv %0d want 1 0 0", se_cnt, pe_cnt, dv_cnt);
    end
    checks++; if (bus.p_data !== model_pdata) begin errors++; $display("FAIL stop_err_hold: got %h want %h", bus.p_data, model_pdata); end
  endtask

  task automatic test_false_start();
    set_cfg(1'b0, 1'b0, 16);
    clear_mon();
    bus.rx_in = 1'b0;
    repeat (3) tick();
    bus.rx_in = 1'b1;
    repeat (40) tick();
    checks++; if (busy_cyc < 1 || busy_cyc >= 16) begin errors++; $display("FAIL false_busy_len: got %0d want 1..15", busy_cyc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL false_busy: got %b want 0", bus.busy); end
    checks++; if (dv_cnt + pe_cnt + se_cnt !== 0) begin
      errors++; $display("FAIL false_pulses: got %0d want 0", dv_cnt + pe_cnt + se_cnt);
    end
  endtask

  task automatic test_rst_mid();
    set_cfg(1'b0, 1'b0, 8);
    drive_bit(1'b0, 8, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, -1);
    bus.rx_in = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    model_pdata = 8'h00;
    checks++; if (bus.busy !== 1'b0 || bus.p_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_state: got busy %b p_data %h want 0 00", bus.busy, bus.p_data);
    end
    rst = 1'b1;
    clear_mon();
    repeat (40) tick();
    checks++; if (busy_cyc + dv_cnt + pe_cnt + se_cnt !== 0) begin
      errors++; $display("FAIL rst_mid_armed: got activity %0d want 0", busy_cyc + dv_cnt + pe_cnt + se_cnt);
    end
    bus.rx_in = 1'b1;
    repeat (8) tick();
    clear_mon();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, -1, 1'b0);
    repeat (4) tick();
    model_pdata = 8'h5A;
    checks++; if (dv_cnt !== 1 || bus.p_data !== 8'h5A) begin
      errors++; $display("FAIL rst_mid_next: got dv %0d p_data %h want 1 5a", dv_cnt, bus.p_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    set_cfg(1'b1, 1'b1, 16);
    clear_mon();
    send_frame(a, 1'b1, ~(^a), 1'b1, 16, -1, 1'b0);
    send_frame(b, 1'b1, ~(^b), 1'b1, 16, -1, 1'b0);
    repeat (4) tick();
    model_pdata = b;
    checks++; if (dv_cnt !== 2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", dv_cnt); end
    if (rx_q.size() == 2) begin
      checks++; if (rx_q[0] !== a || rx_q[1] !== b) begin
        errors++; $display("FAIL b2b_data: got %h %h want %h %h", rx_q[0], rx_q[1], a, b);
      end
    end
  endtask

  task automatic test_spike();
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h08;
`endif
    set_cfg(1'b0, 1'b0, 16);
    clear_mon();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 16, 3, 1'b0);
    repeat (4) tick();
    model_pdata = exp;
    checks++; if (dv_cnt !== 1 || bus.p_data !== exp) begin
      errors++; $display("FAIL spike: got dv %0d p_data %h want 1 %h", dv_cnt, bus.p_data, exp);
    end
  endtask

  task automatic test_random();
    int p;
    logic pe, pt, pbit, sbit;
    logic [7:0] d;
    logic [2:0] exp;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      pe = 1'($urandom); pt = 1'($urandom); d = 8'($urandom);
      pbit = (pt ? ~(^d) : (^d)) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 7) != 0);
      exp = model_frame(d, pe, pt, pbit, sbit);
      if (exp[2]) model_pdata = d;
      set_cfg(pe, pt, p);
      clear_mon();
      send_frame(d, pe, pbit, sbit, p, -1, 1'b1);
      repeat (3 * p + 4) tick();
      checks++; if (dv_cnt !== int'(exp[2])) begin errors++; $display("FAIL rnd%0d_dv: got %0d want %0d", n, dv_cnt, exp[2]); end
      checks++; if (pe_cnt !== int'(exp[1])) begin errors++; $display("FAIL rnd%0d_pe: got %0d want %0d", n, pe_cnt, exp[1]); end
      checks++; if (se_cnt !== int'(exp[0])) begin errors++; $display("FAIL rnd%0d_se: got %0d want %0d", n, se_cnt, exp[0]); end
      checks++; if (bus.p_data !== model_pdata) begin
        errors++; $display("FAIL rnd%0d_p_data: got %h want %h", n, bus.p_data, model_pdata);
      end
    end
  endtask

  initial begin
    bus.rx_in = 1'b1;
    set_cfg(1'b0, 1'b0, 8);
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_false_start();
    test_rst_mid();
    test_back_to_back();
    test_spike();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
